// File: rtl/ppu_pal_pkg.sv
// ppu_pal_pkg: shared palette constants, controller state encoding and address mirroring.
package ppu_pal_pkg;
  localparam int PAL_ENTRIES = 32;
  localparam int PAL_ADDR_W = 5;
  localparam logic [7:0] GREY_MASK = 8'h30;
  typedef enum logic [1:0] {ST_IDLE, ST_CPU, ST_SNAP, ST_DONE} pal_state_t;
  function automatic logic [PAL_ADDR_W-1:0] pal_mirror(input logic [PAL_ADDR_W-1:0] addr);
    return (addr[4] && addr[1:0] == 2'b00) ? {1'b0, addr[3:0]} : addr;
  endfunction
endpackage

// File: rtl/ppu_palette_ram.sv
// ppu_palette_ram: 32-entry palette flop array, one write port, one CPU read port and
// SNAP_LANES snapshot read ports; every port sees the mirrored address.
module ppu_palette_ram
  import ppu_pal_pkg::*;
#(
  parameter int ENTRY_W = 8,
  parameter int SNAP_LANES = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          we,
  input  logic [PAL_ADDR_W-1:0]         waddr,
  input  logic [ENTRY_W-1:0]            wdata,
  input  logic [PAL_ADDR_W-1:0]         raddr,
  output logic [ENTRY_W-1:0]            rdata,
  input  logic [PAL_ADDR_W-1:0]         snap_idx,
  output logic [SNAP_LANES*ENTRY_W-1:0] snap_data
);
  logic [ENTRY_W-1:0] mem [PAL_ENTRIES];
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < PAL_ENTRIES; i++) mem[i] <= '0;
    else if (we) mem[pal_mirror(waddr)] <= wdata;
  assign rdata = mem[pal_mirror(raddr)];
  for (genvar l = 0; l < SNAP_LANES; l++) begin : g_lane
    assign snap_data[l*ENTRY_W +: ENTRY_W] = mem[pal_mirror(snap_idx + PAL_ADDR_W'(l))];
  end
endmodule

// File: rtl/ppu_palette_ctrl.sv
// ppu_palette_ctrl: arbitrates CPU palette accesses against the frame snapshot sequencer.
// Defining PPU_PAL_GREYSCALE_EN adds the greyscale input that masks snapshot entries.
module ppu_palette_ctrl
  import ppu_pal_pkg::*;
#(
  parameter int ENTRY_W = 8,
  parameter int SNAP_LANES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
`ifdef PPU_PAL_GREYSCALE_EN
  input  logic                  greyscale,
`endif
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [PAL_ADDR_W-1:0] cpu_addr,
  input  logic [ENTRY_W-1:0]    cpu_wdata,
  output logic                  cpu_ack,
  output logic [ENTRY_W-1:0]    cpu_rdata,
  input  logic                  snap_req,
  output logic                  snap_busy,
  output logic                  snap_done,
  output logic [16*ENTRY_W-1:0] background_colors,
  output logic [16*ENTRY_W-1:0] sprite_colors
);
  pal_state_t state, state_nx;
  logic [PAL_ADDR_W-1:0] idx;
  logic snap_pend, snap_due, accept;
  logic [ENTRY_W-1:0] rdata;
  logic [SNAP_LANES*ENTRY_W-1:0] snap_data, snap_val;
  logic [PAL_ENTRIES*ENTRY_W-1:0] colors;
  assign snap_due = snap_req | snap_pend;
  assign accept = state == ST_IDLE && !snap_due && cpu_req;
  ppu_palette_ram #(.ENTRY_W(ENTRY_W), .SNAP_LANES(SNAP_LANES)) u_ram (
    .clk(clk), .rst(rst), .we(accept && cpu_we), .waddr(cpu_addr), .wdata(cpu_wdata),
    .raddr(cpu_addr), .rdata(rdata), .snap_idx(idx), .snap_data(snap_data)
  );
`ifdef PPU_PAL_GREYSCALE_EN
  for (genvar l = 0; l < SNAP_LANES; l++) begin : g_grey
    assign snap_val[l*ENTRY_W +: ENTRY_W] = greyscale ?
      snap_data[l*ENTRY_W +: ENTRY_W] & ENTRY_W'(GREY_MASK) : snap_data[l*ENTRY_W +: ENTRY_W];
  end
`else
  assign snap_val = snap_data;
`endif
  always_comb begin
    state_nx = ST_IDLE;
    if (state == ST_IDLE) state_nx = snap_due ? ST_SNAP : cpu_req ? ST_CPU : ST_IDLE;
    else if (state == ST_SNAP)
      state_nx = idx == PAL_ADDR_W'(PAL_ENTRIES - SNAP_LANES) ? ST_DONE : ST_SNAP;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= ST_IDLE;
      idx <= '0;
      snap_pend <= 1'b0;
      cpu_rdata <= '0;
      colors <= '0;
    end else begin
      state <= state_nx;
      idx <= state == ST_SNAP ? idx + PAL_ADDR_W'(SNAP_LANES) : '0;
      // IDLE always launches a due snapshot, so pending only survives outside IDLE
      snap_pend <= state != ST_IDLE && (snap_pend | snap_req);
      if (accept && !cpu_we) cpu_rdata <= rdata;
      if (state == ST_SNAP)
        for (int l = 0; l < SNAP_LANES; l++)
          colors[ENTRY_W*(int'(idx)+l) +: ENTRY_W] <= snap_val[l*ENTRY_W +: ENTRY_W];
    end
  assign cpu_ack = state == ST_CPU;
  assign snap_busy = state == ST_SNAP;
  assign snap_done = state == ST_DONE;
  assign background_colors = colors[16*ENTRY_W-1:0];
  assign sprite_colors = colors[32*ENTRY_W-1:16*ENTRY_W];
endmodule

// File: tb/tb_ppu_palette_ctrl.sv
// tb_ppu_palette_ctrl: directed and randomized checks of the palette controller against
// an array model of the palette with mirroring applied arithmetically.
module tb_ppu_palette_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic greyscale = 1'b0;
  logic cpu_req = 1'b0, cpu_we = 1'b0, snap_req = 1'b0;
  logic [4:0] cpu_addr = '0;
  logic [7:0] cpu_wdata = '0;
  logic cpu_ack, snap_busy, snap_done;
  logic [7:0] cpu_rdata;
  logic [127:0] background_colors, sprite_colors;
  int checks = 0, errors = 0;
  logic [7:0] mem_m [32];
  logic [127:0] last_bg = '0, last_sp = '0;

  ppu_palette_ctrl dut (
    .clk(clk), .rst(rst),
`ifdef PPU_PAL_GREYSCALE_EN
    .greyscale(greyscale),
`endif
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata), .snap_req(snap_req), .snap_busy(snap_busy),
    .snap_done(snap_done), .background_colors(background_colors), .sprite_colors(sprite_colors)
  );

  always #5 clk = ~clk;

  function automatic int mir(int a);
    return (a >= 16 && a % 4 == 0) ? a - 16 : a;
  endfunction

  function automatic logic [127:0] exp_bus(int base);
    logic [127:0] v;
    logic [7:0] e;
    for (int k = 0; k < 16; k++) begin
      e = mem_m[mir(base + k)];
`ifdef PPU_PAL_GREYSCALE_EN
      if (greyscale) e = e & 8'h30;
`endif
      v[8*k +: 8] = e;
    end
    return v;
  endfunction

  task automatic check(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_access(bit we, int addr, logic [7:0] d);
    int n = 0;
    logic [7:0] rd;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = 5'(addr); cpu_wdata = d;
    do begin tick(); n++; end while (!cpu_ack && n < 100);
    check("cpu_latency", 128'(n), 128'd1);
    rd = cpu_rdata;
    cpu_req = 1'b0;
    if (we) mem_m[mir(addr)] = d;
    else check("cpu_rdata", 128'(rd), 128'(mem_m[mir(addr)]));
    tick();
  endtask

  task automatic snapshot(string tag);
    int n = 0;
    snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    while (snap_busy && n < 100) begin n++; tick(); end
    check({tag, "_busy_cycles"}, 128'(n), 128'd32);
    check({tag, "_done"}, 128'(snap_done), 128'd1);
    last_bg = exp_bus(0);
    last_sp = exp_bus(16);
    check({tag, "_bg"}, background_colors, last_bg);
    check({tag, "_sp"}, sprite_colors, last_sp);
    tick();
    check({tag, "_done_pulse"}, 128'(snap_done), 128'd0);
  endtask

  task automatic count_done(int window, output int dn);
    dn = 0;
    for (int w = 0; w < window; w++) begin
      if (snap_done) dn++;
      tick();
    end
  endtask

  initial begin
    int n, done_at, dn;
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_bg", background_colors, '0);
    check("reset_sp", sprite_colors, '0);
    check("reset_flags", {cpu_ack, snap_busy, snap_done}, '0);
    check("reset_rdata", 128'(cpu_rdata), '0);

    // Reset in the middle of a snapshot
    cpu_access(1, 7, 8'h11);
    snapshot("pre_rst");
    cpu_access(1, 9, 8'h22);
    snap_req = 1'b1; tick(); snap_req = 1'b0;
    repeat (10) tick();
    check("mid_busy", 128'(snap_busy), 128'd1);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_bg", background_colors, '0);
    check("rst_mid_sp", sprite_colors, '0);
    check("rst_mid_busy", 128'(snap_busy), '0);
    for (int i = 0; i < 32; i++) mem_m[i] = '0;
    last_bg = '0; last_sp = '0;
    tick();
    rst = 1'b0;
    count_done(40, dn);
    check("rst_no_done", 128'(dn), '0);
    check("rst_idle_bus", background_colors, '0);
    cpu_access(0, 9, 8'h00);

    // Mirrored write then read
    cpu_access(1, 5'h10, 8'h1D);
    cpu_access(0, 5'h00, 8'h00);
    check("mirror_read", 128'(cpu_rdata), 128'h1D);

    // Entry 5 snapshot and bus stability before it
    cpu_access(1, 5, 8'h2A);
    check("bus_stable", background_colors, last_bg);
    snapshot("entry5");
    check("entry5_byte", 128'(background_colors[47:40]), 128'h2A);
    check("sprite16_mirror", 128'(sprite_colors[7:0]), 128'h1D);

    // Simultaneous cpu_req and snap_req: snapshot wins
    cpu_access(1, 6, 8'h33);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd6; snap_req = 1'b1;
    n = 0; done_at = 0;
    do begin
      tick(); n++;
      snap_req = 1'b0;
      if (snap_done) done_at = n;
    end while (!cpu_ack && n < 200);
    check("prio_done_at", 128'(done_at), 128'd33);
    check("prio_ack_at", 128'(n), 128'd35);
    check("prio_rdata", 128'(cpu_rdata), 128'h33);
    cpu_req = 1'b0;
    tick();
    last_bg = exp_bus(0);
    check("prio_bg", background_colors, last_bg);

    // Requests while busy collapse to one extra snapshot
    for (int p = 1; p <= 3; p += 2) begin
      snap_req = 1'b1; tick(); snap_req = 1'b0;
      for (int i = 0; i < p; i++) begin tick(); snap_req = 1'b1; tick(); snap_req = 1'b0; end
      count_done(150, dn);
      check(p == 1 ? "pend_one" : "pend_three", 128'(dn), 128'd2);
    end
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 5'd1;
    tick();
    check("cpu_state_ack", 128'(cpu_ack), 128'd1);
    cpu_req = 1'b0; snap_req = 1'b1;
    tick();
    snap_req = 1'b0;
    count_done(60, dn);
    check("pend_from_cpu", 128'(dn), 128'd1);

`ifdef PPU_PAL_GREYSCALE_EN
    cpu_access(1, 3, 8'h3F);
    greyscale = 1'b1;
    snapshot("grey");
    check("grey_byte", 128'(background_colors[31:24]), 128'h30);
    cpu_access(0, 3, 8'h00);
    check("grey_rdata", 128'(cpu_rdata), 128'h3F);
    greyscale = 1'b0;
`endif

    // Randomized traffic against the model
    for (int it = 0; it < 12; it++) begin
`ifdef PPU_PAL_GREYSCALE_EN
      greyscale = 1'($urandom_range(0, 1));
`endif
      for (int a = 0; a < 6; a++)
        cpu_access(1'($urandom_range(0, 1)), int'($urandom_range(0, 31)), 8'($urandom));
      check("rnd_stable_bg", background_colors, last_bg);
      check("rnd_stable_sp", sprite_colors, last_sp);
      snapshot("rnd");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
